// File: rtl/icache_param.sv
// icache_param: blocking, read-only, set-associative instruction cache.
//
// Sits between the CPU fetch stage and a burst memory read channel. A fetch is
// latched in IDLE, looked up for one cycle, and answered from the array on a
// hit (2 cycles after acceptance). On a miss a line read is issued, beats are
// gathered in a fill buffer, and the line is installed in the victim way. The
// response word is taken from the fill buffer. True LRU uses per-set age
// permutations. A flush (fence.i) invalidates every line in one cycle.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   from_cpu_inst_req_*       fetch request (valid/addr), to_cpu_inst_req_ready
//   to_cpu_cache_rsp_*        instruction response (valid/data), from_cpu_cache_rsp_ready
//   to_mem_rd_req_*           line read request (valid/addr), from_mem_rd_req_ready
//   from_mem_rd_rsp_*         read data beats (valid/data/last), to_mem_rd_rsp_ready
//   flush_req / flush_done    invalidate-all level request / one-cycle completion pulse
//   hit_cnt / miss_cnt        free-running performance counters
module icache_param #(
   parameter int SETS       = 8,
   parameter int WAYS       = 4,
   parameter int LINE_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        from_cpu_inst_req_valid,
   input  logic [31:0] from_cpu_inst_req_addr,
   output logic        to_cpu_inst_req_ready,
   output logic        to_cpu_cache_rsp_valid,
   output logic [31:0] to_cpu_cache_rsp_data,
   input  logic        from_cpu_cache_rsp_ready,
   output logic        to_mem_rd_req_valid,
   output logic [31:0] to_mem_rd_req_addr,
   input  logic        from_mem_rd_req_ready,
   input  logic        from_mem_rd_rsp_valid,
   input  logic [31:0] from_mem_rd_rsp_data,
   input  logic        from_mem_rd_rsp_last,
   output logic        to_mem_rd_rsp_ready,
   input  logic        flush_req,
   output logic        flush_done,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int IDX_W  = $clog2(SETS);
   localparam int WO_W   = $clog2(LINE_WORDS);
   localparam int OFF_W  = WO_W + 2;
   localparam int TAG_W  = 32 - IDX_W - OFF_W;
   localparam int AGE_W  = $clog2(WAYS);
   localparam int BEAT_W = WO_W + 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, RESP, MEM_RD, RECV, REFILL, FLUSH} state_t;
   typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

   // Control state (reset)
   state_t            state_q, state_d;
   logic [29:0]       addr_q, addr_d;          // word address, byte offset dropped
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   valid_d [SETS];
   ages_t             age_q [SETS];
   ages_t             age_d [SETS];
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [AGE_W-1:0]  victim_q, victim_d;
   logic              flush_ign_q, flush_ign_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_data_q, rsp_data_d;
   logic              mreq_valid_q, mreq_valid_d;
   logic [31:0]       mreq_addr_q, mreq_addr_d;
   logic              mrsp_ready_q, mrsp_ready_d;
   logic              flush_done_q, flush_done_d;
   logic [31:0]       hit_cnt_q, hit_cnt_d;
   logic [31:0]       miss_cnt_q, miss_cnt_d;

   // Storage (no reset; qualified by valid bits / cleared on refill start)
   logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
   logic [TAG_W-1:0]  tag_d  [SETS][WAYS];
   logic [31:0]       data_q [SETS][WAYS][LINE_WORDS];
   logic [31:0]       data_d [SETS][WAYS][LINE_WORDS];
   logic [31:0]       fill_q [LINE_WORDS];
   logic [31:0]       fill_d [LINE_WORDS];

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic [WO_W-1:0]   req_wo;
   logic              hit;
   logic [AGE_W-1:0]  hit_way;
   logic [AGE_W-1:0]  victim;
   logic              unused_addr_bits;

   assign req_tag = addr_q[29 -: TAG_W];
   assign req_idx = addr_q[WO_W +: IDX_W];
   assign req_wo  = addr_q[WO_W-1:0];
   assign unused_addr_bits = ^from_cpu_inst_req_addr[1:0];

   // A pending flush blocks acceptance in the same IDLE cycle, except in the
   // IDLE cycle right after a flush, where the requester is dropping it.
   assign to_cpu_inst_req_ready  = ready_q & ~(flush_req & ~flush_ign_q);
   assign to_cpu_cache_rsp_valid = rsp_valid_q;
   assign to_cpu_cache_rsp_data  = rsp_data_q;
   assign to_mem_rd_req_valid    = mreq_valid_q;
   assign to_mem_rd_req_addr     = mreq_addr_q;
   assign to_mem_rd_rsp_ready    = mrsp_ready_q;
   assign flush_done             = flush_done_q;
   assign hit_cnt                = hit_cnt_q;
   assign miss_cnt               = miss_cnt_q;

   // Accessed way becomes age 0; ways younger than its old age move one older.
   function automatic ages_t lru_touch(input ages_t a, input logic [AGE_W-1:0] way);
      ages_t r;
      logic [AGE_W-1:0] old;
      old = a[way];
      for (int w = 0; w < WAYS; w++) begin
         if (AGE_W'(w) == way)  r[w] = '0;
         else if (a[w] < old)   r[w] = a[w] + 1'b1;
         else                   r[w] = a[w];
      end
      return r;
   endfunction

   // Tag compare and victim choice: lowest invalid way, else the oldest way.
   always_comb begin
      logic             inv_found;
      logic [AGE_W-1:0] inv_way;
      logic [AGE_W-1:0] old_way;
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      old_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
         if (age_q[req_idx][w] == AGE_W'(WAYS-1)) old_way = AGE_W'(w);
      end
      for (int w = WAYS-1; w >= 0; w--) begin
         if (!valid_q[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = AGE_W'(w);
         end
      end
      victim = inv_found ? inv_way : old_way;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      age_d       = age_q;
      beat_d      = beat_q;
      victim_d    = victim_q;
      flush_ign_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      mreq_addr_d = mreq_addr_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      tag_d       = tag_q;
      data_d      = data_q;
      fill_d      = fill_q;
      case (state_q)
         IDLE: begin
            if (flush_req && !flush_ign_q) begin
               state_d = FLUSH;
            end else if (from_cpu_inst_req_valid && to_cpu_inst_req_ready) begin
               addr_d  = from_cpu_inst_req_addr[31:2];
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               hit_cnt_d      = hit_cnt_q + 32'd1;
               age_d[req_idx] = lru_touch(age_q[req_idx], hit_way);
               rsp_data_d     = data_q[req_idx][hit_way][req_wo];
               state_d        = RESP;
            end else begin
               miss_cnt_d  = miss_cnt_q + 32'd1;
               victim_d    = victim;
               mreq_addr_d = {addr_q[29:WO_W], {OFF_W{1'b0}}};
               state_d     = MEM_RD;
            end
         end
         MEM_RD: begin
            if (from_mem_rd_req_ready) begin
               beat_d = '0;
               for (int i = 0; i < LINE_WORDS; i++) fill_d[i] = '0;
               state_d = RECV;
            end
         end
         RECV: begin
            if (from_mem_rd_rsp_valid) begin
               // Beats past the line length are dropped; counter saturates.
               if (beat_q < BEAT_W'(LINE_WORDS)) begin
                  fill_d[beat_q[WO_W-1:0]] = from_mem_rd_rsp_data;
                  beat_d = beat_q + 1'b1;
               end
               if (from_mem_rd_rsp_last) state_d = REFILL;
            end
         end
         REFILL: begin
            tag_d[req_idx][victim_q]   = req_tag;
            valid_d[req_idx][victim_q] = 1'b1;
            for (int i = 0; i < LINE_WORDS; i++) data_d[req_idx][victim_q][i] = fill_q[i];
            age_d[req_idx] = lru_touch(age_q[req_idx], victim_q);
            rsp_data_d     = fill_q[req_wo];
            state_d        = RESP;
         end
         RESP: begin
            if (from_cpu_cache_rsp_ready) state_d = IDLE;
         end
         FLUSH: begin
            for (int s = 0; s < SETS; s++) valid_d[s] = '0;
            flush_ign_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Outputs are registered from the next state.
      ready_d      = (state_d == IDLE);
      rsp_valid_d  = (state_d == RESP);
      mreq_valid_d = (state_d == MEM_RD);
      mrsp_ready_d = (state_d == RECV);
      flush_done_d = (state_d == FLUSH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
         end
         beat_q       <= '0;
         victim_q     <= '0;
         flush_ign_q  <= 1'b0;
         ready_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         mreq_valid_q <= 1'b0;
         mreq_addr_q  <= '0;
         mrsp_ready_q <= 1'b0;
         flush_done_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         valid_q      <= valid_d;
         age_q        <= age_d;
         beat_q       <= beat_d;
         victim_q     <= victim_d;
         flush_ign_q  <= flush_ign_d;
         ready_q      <= ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         mreq_valid_q <= mreq_valid_d;
         mreq_addr_q  <= mreq_addr_d;
         mrsp_ready_q <= mrsp_ready_d;
         flush_done_q <= flush_done_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
      fill_q <= fill_d;
   end

endmodule

// File: tb/tb_icache_param.sv
module tb_icache_param;
   localparam int SETS       = 8;
   localparam int WAYS       = 4;
   localparam int LINE_WORDS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        from_cpu_inst_req_valid;
   logic [31:0] from_cpu_inst_req_addr;
   logic        to_cpu_inst_req_ready;
   logic        to_cpu_cache_rsp_valid;
   logic [31:0] to_cpu_cache_rsp_data;
   logic        from_cpu_cache_rsp_ready;
   logic        to_mem_rd_req_valid;
   logic [31:0] to_mem_rd_req_addr;
   logic        from_mem_rd_req_ready;
   logic        from_mem_rd_rsp_valid;
   logic [31:0] from_mem_rd_rsp_data;
   logic        from_mem_rd_rsp_last;
   logic        to_mem_rd_rsp_ready;
   logic        flush_req;
   logic        flush_done;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   icache_param #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS)) dut (
      .clk(clk), .rst(rst),
      .from_cpu_inst_req_valid(from_cpu_inst_req_valid),
      .from_cpu_inst_req_addr(from_cpu_inst_req_addr),
      .to_cpu_inst_req_ready(to_cpu_inst_req_ready),
      .to_cpu_cache_rsp_valid(to_cpu_cache_rsp_valid),
      .to_cpu_cache_rsp_data(to_cpu_cache_rsp_data),
      .from_cpu_cache_rsp_ready(from_cpu_cache_rsp_ready),
      .to_mem_rd_req_valid(to_mem_rd_req_valid),
      .to_mem_rd_req_addr(to_mem_rd_req_addr),
      .from_mem_rd_req_ready(from_mem_rd_req_ready),
      .from_mem_rd_rsp_valid(from_mem_rd_rsp_valid),
      .from_mem_rd_rsp_data(from_mem_rd_rsp_data),
      .from_mem_rd_rsp_last(from_mem_rd_rsp_last),
      .to_mem_rd_rsp_ready(to_mem_rd_rsp_ready),
      .flush_req(flush_req),
      .flush_done(flush_done),
      .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory contents and burst shape ----------------
   function automatic logic [31:0] mem_fn(input logic [31:0] line, input int i);
      logic [4:0] i5;
      i5 = i[4:0];
      if (line == 32'h0000_1000) return 32'h100 + i;
      return {line[31:5], i5} ^ 32'hA500_0000;
   endfunction

   // Tag 0x14 bursts end early, tag 0x15 bursts overrun the line.
   function automatic int nbeats(input logic [31:0] line);
      if (line[31:8] == 24'h14) return 5;
      if (line[31:8] == 24'h15) return LINE_WORDS + 2;
      return LINE_WORDS;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] line;
      int off;
      line = a & ~32'h1f;
      off  = int'(a[4:2]);
      if (off < nbeats(line)) return mem_fn(line, off);
      return 32'h0;
   endfunction

   function automatic logic [31:0] mk(input int tag, input int set, input int off);
      logic [23:0] t; logic [2:0] s; logic [2:0] o;
      t = tag[23:0]; s = set[2:0]; o = off[2:0];
      return {t, s, o, 2'b00};
   endfunction

   // ---------------- reference model: per-set recency lists ----------------
   int unsigned mt [SETS][WAYS];   // mt[s][0] is most recently used
   int          mn [SETS];
   int          model_hits, model_misses;

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) mn[s] = 0;
      model_hits = 0;
      model_misses = 0;
   endtask

   task automatic model_flush();
      for (int s = 0; s < SETS; s++) mn[s] = 0;
   endtask

   task automatic model_access(input logic [31:0] line, output bit h);
      int s; int unsigned t; int p;
      s = int'(line[7:5]);
      t = int'(line[31:8]);
      p = -1;
      for (int i = 0; i < mn[s]; i++) if (mt[s][i] == t) p = i;
      if (p >= 0) begin
         h = 1'b1;
         model_hits++;
      end else begin
         h = 1'b0;
         model_misses++;
         if (mn[s] < WAYS) mn[s]++;
         p = mn[s] - 1;          // least recent entry (or fresh slot) is replaced
      end
      for (int i = p; i > 0; i--) mt[s][i] = mt[s][i-1];
      mt[s][0] = t;
   endtask

   // ---------------- scoreboard queues ----------------
   typedef struct { logic [31:0] data; bit hit; int acc; } exp_t;
   exp_t        rsp_q[$];
   logic [31:0] mreq_q[$];

   int beat_limit = 1000;
   bit mem_stalled = 1'b0;
   int beats_taken = 0;
   bit hold_low = 1'b0;
   int flush_pulses = 0;

   // ---------------- CPU response monitor ----------------
   initial begin : monitor
      bit          in_rsp;
      int          first;
      logic [31:0] held;
      exp_t        e;
      in_rsp = 1'b0;
      first = 0;
      held = '0;
      from_cpu_cache_rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (flush_done) flush_pulses++;
         if (!rst) begin
            in_rsp = 1'b0;
            from_cpu_cache_rsp_ready = 1'b0;
         end else begin
            from_cpu_cache_rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (to_cpu_cache_rsp_valid) begin
               if (!in_rsp) begin
                  in_rsp = 1'b1;
                  first  = cyc;
                  held   = to_cpu_cache_rsp_data;
               end else begin
                  chk("rsp_data_stable", to_cpu_cache_rsp_data, held);
               end
               if (from_cpu_cache_rsp_ready) begin
                  in_rsp = 1'b0;
                  if (rsp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL rsp_unexpected actual=0x%08h required=no response", to_cpu_cache_rsp_data);
                  end else begin
                     e = rsp_q.pop_front();
                     chk("rsp_data", to_cpu_cache_rsp_data, e.data);
                     if (e.hit) chk("hit_latency", 32'(first - e.acc), 32'd2);
                     else       chk("miss_latency_min", 32'(first - e.acc >= 5), 32'd1);
                  end
               end
            end
         end
      end
   end

   // ---------------- memory responder ----------------
   task automatic serve();
      logic [31:0] line;
      int nb, lim, n;
      bit hs;
      mem_stalled = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      line = to_mem_rd_req_addr;
      if (mreq_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL mem_req_unexpected actual=0x%08h required=no request", line);
      end else begin
         chk("mem_req_addr", line, mreq_q.pop_front());
      end
      from_mem_rd_req_ready = 1'b1;
      @(negedge clk);
      from_mem_rd_req_ready = 1'b0;
      nb = nbeats(line);
      lim = (nb < beat_limit) ? nb : beat_limit;
      beats_taken = 0;
      for (int i = 0; i < lim; i++) begin
         repeat ($urandom_range(0, 1)) @(negedge clk);
         from_mem_rd_rsp_valid = 1'b1;
         from_mem_rd_rsp_data  = mem_fn(line, i);
         from_mem_rd_rsp_last  = (i == nb - 1);
         n = 0;
         do begin
            hs = to_mem_rd_rsp_ready;
            @(negedge clk);
            n++;
         end while (!hs && n < 1000);
         if (!hs) begin
            $display("FAIL mem_beat_timeout actual=no rsp_ready required=rsp_ready");
            $fatal(1, "beat never accepted");
         end
         beats_taken++;
         from_mem_rd_rsp_valid = 1'b0;
         from_mem_rd_rsp_last  = 1'b0;
      end
      if (lim < nb) mem_stalled = 1'b1;
   endtask

   initial begin : responder
      from_mem_rd_req_ready = 1'b0;
      from_mem_rd_rsp_valid = 1'b0;
      from_mem_rd_rsp_data  = '0;
      from_mem_rd_rsp_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && to_mem_rd_req_valid) serve();
      end
   end

   // ---------------- stimulus ----------------
   task automatic fetch(input logic [31:0] a);
      bit h;
      int n;
      exp_t e;
      from_cpu_inst_req_valid = 1'b1;
      from_cpu_inst_req_addr  = a;
      n = 0;
      while (!to_cpu_inst_req_ready) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            $display("FAIL accept_timeout actual=ready low required=ready high");
            $fatal(1, "request never accepted");
         end
      end
      model_access(a & ~32'h1f, h);
      e.data = exp_word(a);
      e.hit  = h;
      e.acc  = cyc;
      rsp_q.push_back(e);
      if (!h) mreq_q.push_back(a & ~32'h1f);
      @(negedge clk);
      from_cpu_inst_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (rsp_q.size() != 0 || !to_cpu_inst_req_ready) begin
         @(negedge clk);
         n++;
         if (n > 3000) begin
            $display("FAIL idle_timeout actual=busy required=idle");
            $fatal(1, "cache never returned to idle");
         end
      end
   endtask

   task automatic do_flush();
      int n, p0;
      p0 = flush_pulses;
      flush_req = 1'b1;
      n = 0;
      while (!flush_done) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            $display("FAIL flush_timeout actual=no flush_done required=flush_done");
            $fatal(1, "flush never completed");
         end
      end
      flush_req = 1'b0;
      model_flush();
      repeat (3) @(negedge clk);
      chk("flush_done_once", 32'(flush_pulses - p0), 32'd1);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_inst_req_ready"}, {31'd0, to_cpu_inst_req_ready}, 32'd0);
      chk({tag, "_rsp_valid"},      {31'd0, to_cpu_cache_rsp_valid}, 32'd0);
      chk({tag, "_rsp_data"},       to_cpu_cache_rsp_data, 32'd0);
      chk({tag, "_mem_req_valid"},  {31'd0, to_mem_rd_req_valid}, 32'd0);
      chk({tag, "_mem_req_addr"},   to_mem_rd_req_addr, 32'd0);
      chk({tag, "_mem_rsp_ready"},  {31'd0, to_mem_rd_rsp_ready}, 32'd0);
      chk({tag, "_flush_done"},     {31'd0, flush_done}, 32'd0);
      chk({tag, "_hit_cnt"},        hit_cnt, 32'd0);
      chk({tag, "_miss_cnt"},       miss_cnt, 32'd0);
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_hit_cnt"},  hit_cnt,  32'(model_hits));
      chk({tag, "_miss_cnt"}, miss_cnt, 32'(model_misses));
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin : stim
      int n;
      rst = 1'b0;
      from_cpu_inst_req_valid = 1'b0;
      from_cpu_inst_req_addr  = '0;
      flush_req = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b1;
      #1;
      chk("ready_before_first_edge", {31'd0, to_cpu_inst_req_ready}, 32'd0);
      @(negedge clk);
      chk("ready_in_idle", {31'd0, to_cpu_inst_req_ready}, 32'd1);

      // cold miss, then hits in the same line
      fetch(32'h0000_1004);
      wait_idle();
      chk("cold_beats", 32'(beats_taken), 32'(nbeats(32'h0000_1000)));
      chk_counters("cold");
      fetch(32'h0000_1004);
      fetch(32'h0000_101C);
      wait_idle();
      chk_counters("refetch");

      // LRU in set 1: A B C D, touch A, E evicts B, A still hits, B misses
      fetch(mk(24'h10, 1, 0));
      fetch(mk(24'h11, 1, 1));
      fetch(mk(24'h12, 1, 2));
      fetch(mk(24'h13, 1, 3));
      fetch(mk(24'h10, 1, 4));
      fetch(mk(24'h14, 1, 6));
      fetch(mk(24'h10, 1, 7));
      fetch(mk(24'h11, 1, 5));
      wait_idle();
      chk_counters("lru");

      // CPU back-pressure on a hit
      hold_low = 1'b1;
      fetch(32'h0000_1004);
      from_cpu_inst_req_valid = 1'b1;
      from_cpu_inst_req_addr  = 32'h0000_1008;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("hold_rsp_valid", {31'd0, to_cpu_cache_rsp_valid}, 32'd1);
         chk("hold_rsp_data",  to_cpu_cache_rsp_data, exp_word(32'h0000_1004));
         chk("hold_req_ready", {31'd0, to_cpu_inst_req_ready}, 32'd0);
         chk_counters("hold");
         @(negedge clk);
      end
      from_cpu_inst_req_valid = 1'b0;
      hold_low = 1'b0;
      wait_idle();

      // flush together with a request: flush wins, then the line misses
      begin
         int p0;
         p0 = flush_pulses;
         flush_req = 1'b1;
         from_cpu_inst_req_valid = 1'b1;
         from_cpu_inst_req_addr  = 32'h0000_1004;
         #1;
         chk("flush_blocks_ready", {31'd0, to_cpu_inst_req_ready}, 32'd0);
         n = 0;
         while (!flush_done) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
               $display("FAIL flush_timeout actual=no flush_done required=flush_done");
               $fatal(1, "flush never completed");
            end
         end
         flush_req = 1'b0;
         model_flush();
         fetch(32'h0000_1004);
         wait_idle();
         chk("flush_with_req_once", 32'(flush_pulses - p0), 32'd1);
         chk_counters("after_flush");
      end

      // randomized traffic with occasional flushes
      for (int k = 0; k < 250; k++) begin
         if ($urandom_range(0, 24) == 0) begin
            wait_idle();
            do_flush();
         end else begin
            fetch(mk(24'h10 + $urandom_range(0, 5), $urandom_range(0, SETS-1),
                     $urandom_range(0, LINE_WORDS-1)));
         end
      end
      wait_idle();
      chk_counters("random");

      // reset during a refill, after the third beat
      do_flush();
      beat_limit = 3;
      fetch(32'h0000_1004);
      n = 0;
      while (!mem_stalled) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            $display("FAIL stall_timeout actual=no stall required=3 beats");
            $fatal(1, "refill never reached beat 3");
         end
      end
      chk("partial_beats", 32'(beats_taken), 32'd3);
      rst = 1'b0;
      #1;
      chk_zero_outputs("midrefill_reset");
      repeat (2) @(negedge clk);
      rsp_q.delete();
      mreq_q.delete();
      model_reset();
      beat_limit = 1000;
      rst = 1'b1;
      fetch(32'h0000_1004);
      wait_idle();
      chk_counters("post_reset");
      chk("mreq_drained", 32'(mreq_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
